// File: rtl/shiyan_pkg.sv
// shiyan_pkg: shared constants and the FSM state type for the shiyan test
// sequencer. Holds the data widths of the conversion chain, the default
// per-word timeout and the default counter width.
package shiyan_pkg;

    localparam int unsigned TIMEOUT_CYC_DEF = 1023;
    localparam int unsigned CNT_W_DEF       = 10;
    localparam int unsigned WORD_W          = 16;
    localparam int unsigned RESULT_W        = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_WAIT,
        ST_CHECK,
        ST_FIN
    } state_e;

endpackage

// File: rtl/shiyan_sequencer_if.sv
// shiyan_sequencer_if: bundles the sequencer's control, word-source,
// conversion-chain and result signals.
//   master : sequencer side (drives word_req, input_binary, en_shiyan, busy,
//            seq_done, pass_cnt, fail_cnt, timeout_cnt, last_fail)
//   slave  : environment side (drives start, num_words, word_in, word_valid,
//            all_done, out_b)
interface shiyan_sequencer_if
    import shiyan_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
);

    logic                start;
    logic [CNT_W-1:0]    num_words;
    logic                word_req;
    logic [WORD_W-1:0]   word_in;
    logic                word_valid;
    logic [WORD_W-1:0]   input_binary;
    logic                en_shiyan;
    logic                all_done;
    logic [RESULT_W-1:0] out_b;
    logic                busy;
    logic                seq_done;
    logic [CNT_W-1:0]    pass_cnt;
    logic [CNT_W-1:0]    fail_cnt;
    logic [CNT_W-1:0]    timeout_cnt;
    logic [WORD_W-1:0]   last_fail;

    modport master (
        input  start, num_words, word_in, word_valid, all_done, out_b,
        output word_req, input_binary, en_shiyan, busy, seq_done,
               pass_cnt, fail_cnt, timeout_cnt, last_fail
    );

    modport slave (
        output start, num_words, word_in, word_valid, all_done, out_b,
        input  word_req, input_binary, en_shiyan, busy, seq_done,
               pass_cnt, fail_cnt, timeout_cnt, last_fail
    );

endinterface

// File: rtl/shiyan_timer.sv
// shiyan_timer: per-word timeout counter.
//   clk, rst : clock, asynchronous active-low reset
//   clr      : restart the count at zero
//   en       : count this cycle
//   expired  : high in the TIMEOUT_CYC-th enabled cycle after clr
module shiyan_timer
    import shiyan_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned   TW   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && count_q != LAST) begin
            count_d = count_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Combinational so the FSM can leave WAIT in the expiring cycle itself.
    assign expired = en && (count_q == LAST);

endmodule

// File: rtl/shiyan_sequencer.sv
// shiyan_sequencer: fetches num_words test words one at a time, launches each
// into the conversion chain, checks the recovered value and tallies
// pass / fail / timeout results.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : shiyan_sequencer_if.master (start/num_words control, word
//              source handshake, conversion chain launch/return, status and
//              result counters)
module shiyan_sequencer
    import shiyan_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input logic                clk,
    input logic                rst,
    shiyan_sequencer_if.master bus
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    remain_q, remain_d;
    logic [WORD_W-1:0]   input_binary_q, input_binary_d;
    logic [RESULT_W-1:0] out_b_q, out_b_d;
    logic                timed_out_q, timed_out_d;
    logic                word_req_q, word_req_d;
    logic                en_shiyan_q, en_shiyan_d;
    logic                busy_q, busy_d;
    logic                seq_done_q, seq_done_d;
    logic [CNT_W-1:0]    pass_q, pass_d;
    logic [CNT_W-1:0]    fail_q, fail_d;
    logic [CNT_W-1:0]    to_q, to_d;
    logic [WORD_W-1:0]   last_fail_q, last_fail_d;
    logic                expired;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    shiyan_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_q == ST_ISSUE),
        .en      (state_q == ST_WAIT),
        .expired (expired)
    );

    always_comb begin
        state_d        = state_q;
        remain_d       = remain_q;
        input_binary_d = input_binary_q;
        out_b_d        = out_b_q;
        timed_out_d    = timed_out_q;
        pass_d         = pass_q;
        fail_d         = fail_q;
        to_d           = to_q;
        last_fail_d    = last_fail_q;
        word_req_d     = 1'b0;
        en_shiyan_d    = 1'b0;
        seq_done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.num_words != '0) begin
                        pass_d     = '0;
                        fail_d     = '0;
                        to_d       = '0;
                        remain_d   = bus.num_words;
                        word_req_d = 1'b1;
                        state_d    = ST_FETCH;
                    end else begin
                        seq_done_d = 1'b1;
                    end
                end
            end
            ST_FETCH: begin
                if (bus.word_valid) begin
                    input_binary_d = bus.word_in;
                    state_d        = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Registered launch lands in the first WAIT cycle, giving the
                // two-cycle word_valid -> en_shiyan latency.
                en_shiyan_d = 1'b1;
                timed_out_d = 1'b0;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                // all_done is tested first so it wins over a same-cycle expiry.
                if (bus.all_done) begin
                    out_b_d = bus.out_b;
                    state_d = ST_CHECK;
                end else if (expired) begin
                    timed_out_d = 1'b1;
                    to_d        = sat_inc(to_q);
                    last_fail_d = input_binary_q;
                    state_d     = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!timed_out_q) begin
                    if (out_b_q[RESULT_W-1:WORD_W] == '0 &&
                        out_b_q[WORD_W-1:0] == input_binary_q) begin
                        pass_d = sat_inc(pass_q);
                    end else begin
                        fail_d      = sat_inc(fail_q);
                        last_fail_d = input_binary_q;
                    end
                end
                remain_d = remain_q - CNT_W'(1);
                if (remain_q == CNT_W'(1)) begin
                    seq_done_d = 1'b1;
                    state_d    = ST_FIN;
                end else begin
                    word_req_d = 1'b1;
                    state_d    = ST_FETCH;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            remain_q       <= '0;
            input_binary_q <= '0;
            out_b_q        <= '0;
            timed_out_q    <= 1'b0;
            word_req_q     <= 1'b0;
            en_shiyan_q    <= 1'b0;
            busy_q         <= 1'b0;
            seq_done_q     <= 1'b0;
            pass_q         <= '0;
            fail_q         <= '0;
            to_q           <= '0;
            last_fail_q    <= '0;
        end else begin
            state_q        <= state_d;
            remain_q       <= remain_d;
            input_binary_q <= input_binary_d;
            out_b_q        <= out_b_d;
            timed_out_q    <= timed_out_d;
            word_req_q     <= word_req_d;
            en_shiyan_q    <= en_shiyan_d;
            busy_q         <= busy_d;
            seq_done_q     <= seq_done_d;
            pass_q         <= pass_d;
            fail_q         <= fail_d;
            to_q           <= to_d;
            last_fail_q    <= last_fail_d;
        end
    end

    assign bus.word_req     = word_req_q;
    assign bus.input_binary = input_binary_q;
    assign bus.en_shiyan    = en_shiyan_q;
    assign bus.busy         = busy_q;
    assign bus.seq_done     = seq_done_q;
    assign bus.pass_cnt     = pass_q;
    assign bus.fail_cnt     = fail_q;
    assign bus.timeout_cnt  = to_q;
    assign bus.last_fail    = last_fail_q;

endmodule

// File: tb/tb_shiyan_sequencer.sv
// tb_shiyan_sequencer: directed and randomized runs of shiyan_sequencer with
// a word-level reference model (per-word outcome from the returned value and
// the cycle in which all_done arrives).
module tb_shiyan_sequencer;
    import shiyan_pkg::*;

    localparam int unsigned TO   = 16;
    localparam int unsigned CW   = 10;
    localparam int          MAXC = (1 << CW) - 1;

    // k: WAIT cycle (1 = cycle of en_shiyan) in which all_done is driven,
    //    0 = never; fd: idle cycles before word_valid.
    typedef struct {
        logic [15:0] w;
        logic [31:0] ob;
        int          k;
        int          fd;
    } item_t;

    logic        clk = 1'b0;
    logic        rst;
    int          checks = 0;
    int          errors = 0;
    int          exp_pass = 0;
    int          exp_fail = 0;
    int          exp_to = 0;
    logic [15:0] exp_last = '0;
    item_t       items[$];

    shiyan_sequencer_if #(.CNT_W(CW)) bus ();

    shiyan_sequencer #(
        .TIMEOUT_CYC(TO),
        .CNT_W      (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add_item(input logic [15:0] w, input logic [31:0] ob, input int k, input int fd);
        item_t it;
        it.w = w; it.ob = ob; it.k = k; it.fd = fd;
        items.push_back(it);
    endtask

    task automatic add_random(input int n);
        logic [15:0] w;
        logic [31:0] ob;
        int          k;
        for (int i = 0; i < n; i++) begin
            w = 16'($urandom);
            case ($urandom_range(0, 3))
                0, 1: ob = {16'h0000, w};
                2:    ob = {16'h0000, w ^ (16'h1 << $urandom_range(0, 15))};
                default: ob = {16'($urandom_range(1, 65535)), w};
            endcase
            case ($urandom_range(0, 5))
                0:       k = 0;
                1:       k = TO + 1;
                2:       k = TO;
                default: k = $urandom_range(1, TO - 1);
            endcase
            add_item(w, ob, k, $urandom_range(0, 3));
        end
    endtask

    task automatic clear_inputs();
        bus.start = 1'b0; bus.num_words = '0; bus.word_in = '0;
        bus.word_valid = 1'b0; bus.all_done = 1'b0; bus.out_b = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_word_req"}, bus.word_req, 0);
        check({tag, "_en_shiyan"}, bus.en_shiyan, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_seq_done"}, bus.seq_done, 0);
        check({tag, "_pass"}, bus.pass_cnt, 0);
        check({tag, "_fail"}, bus.fail_cnt, 0);
        check({tag, "_timeout"}, bus.timeout_cnt, 0);
        check({tag, "_last_fail"}, bus.last_fail, 0);
        check({tag, "_input_binary"}, bus.input_binary, 0);
    endtask

    task automatic do_abort();
        #3 rst = 1'b0;
        #1;
        check_all_zero("mid_reset");
        exp_pass = 0; exp_fail = 0; exp_to = 0; exp_last = '0;
        clear_inputs();
        repeat (3) begin
            @(negedge clk);
            check("reset_no_seq_done", bus.seq_done, 0);
        end
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("no_resume_busy", bus.busy, 0);
            check("no_resume_word_req", bus.word_req, 0);
        end
    endtask

    // Runs the words in items; abort_word >= 0 resets during that word's WAIT.
    task automatic do_run(input int abort_word);
        int    n;
        int    j;
        int    exp_j;
        bit    found;
        bit    timed;
        item_t it;
        n = items.size();
        @(negedge clk);
        bus.start = 1'b1; bus.num_words = CW'(n);
        @(negedge clk);
        bus.start = 1'b0; bus.num_words = CW'($urandom);
        if (n == 0) begin
            check("zero_seq_done", bus.seq_done, 1);
            check("zero_busy", bus.busy, 0);
            check("zero_word_req", bus.word_req, 0);
            @(negedge clk);
            check("zero_seq_done_end", bus.seq_done, 0);
            check("zero_word_req_end", bus.word_req, 0);
            check("zero_en_shiyan", bus.en_shiyan, 0);
            check("zero_pass_kept", bus.pass_cnt, exp_pass);
            check("zero_fail_kept", bus.fail_cnt, exp_fail);
            return;
        end
        exp_pass = 0; exp_fail = 0; exp_to = 0;
        check("run_busy", bus.busy, 1);
        check("first_word_req", bus.word_req, 1);
        for (int i = 0; i < n; i++) begin
            it = items[i];
            for (int d = 0; d < it.fd; d++) begin
                bus.word_valid = 1'b0;
                bus.all_done   = 1'($urandom);
                bus.word_in    = 16'($urandom);
                @(negedge clk);
                check("word_req_once", bus.word_req, 0);
            end
            bus.word_valid = 1'b1; bus.word_in = it.w;
            @(negedge clk);
            bus.word_valid = 1'($urandom); bus.word_in = 16'($urandom);
            bus.all_done   = 1'($urandom);
            check("en_early", bus.en_shiyan, 0);
            @(negedge clk);
            check("en_latency", bus.en_shiyan, 1);
            check("input_binary", bus.input_binary, it.w);
            timed = !(it.k >= 1 && it.k <= TO);
            exp_j = timed ? TO + 2 : it.k + 2;
            found = 1'b0;
            j = 1;
            while (!found && j <= 40) begin
                bus.start = 1'b0;
                if (j > 1 && (bus.word_req || bus.seq_done)) begin
                    found = 1'b1;
                end else begin
                    if (i == abort_word && j == 3) begin
                        do_abort();
                        return;
                    end
                    if (j == 2) begin
                        check("en_one_cycle", bus.en_shiyan, 0);
                        bus.start = 1'($urandom);
                        bus.num_words = CW'($urandom);
                    end
                    if (!timed && j == it.k + 1) begin
                        check("cnt_not_early_pass", bus.pass_cnt, exp_pass);
                        check("cnt_not_early_fail", bus.fail_cnt, exp_fail);
                    end
                    bus.all_done   = (j == it.k);
                    bus.out_b      = (j == it.k) ? it.ob : $urandom;
                    bus.word_valid = 1'($urandom);
                    @(negedge clk);
                    j++;
                end
            end
            bus.all_done = 1'b0; bus.word_valid = 1'b0; bus.start = 1'b0;
            if (!found) begin
                check("event_timeout", 0, 1);
                return;
            end
            if (timed) begin
                if (exp_to < MAXC) exp_to++;
                exp_last = it.w;
            end else if (it.ob == {16'h0000, it.w}) begin
                if (exp_pass < MAXC) exp_pass++;
            end else begin
                if (exp_fail < MAXC) exp_fail++;
                exp_last = it.w;
            end
            check("result_cycle", j, exp_j);
            check("pass_cnt", bus.pass_cnt, exp_pass);
            check("fail_cnt", bus.fail_cnt, exp_fail);
            check("timeout_cnt", bus.timeout_cnt, exp_to);
            check("last_fail", bus.last_fail, exp_last);
            check("busy_in_run", bus.busy, 1);
            if (i == n - 1) begin
                check("fin_seq_done", bus.seq_done, 1);
                check("fin_word_req", bus.word_req, 0);
            end else begin
                check("next_word_req", bus.word_req, 1);
                check("no_early_seq_done", bus.seq_done, 0);
            end
        end
        @(negedge clk);
        check("end_busy", bus.busy, 0);
        check("end_seq_done_pulse", bus.seq_done, 0);
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);
        check("idle_busy", bus.busy, 0);

        // Three zero-extended echoes all pass.
        items.delete();
        add_item(16'h0001, 32'h0000_0001, 3, 0);
        add_item(16'h00FF, 32'h0000_00FF, 5, 2);
        add_item(16'hFFFF, 32'h0000_FFFF, 1, 1);
        do_run(-1);
        check("three_words_pass", bus.pass_cnt, 3);

        // Off-by-one return fails.
        items.delete();
        add_item(16'h1234, 32'h0000_1235, 4, 0);
        do_run(-1);
        check("mismatch_fail", bus.fail_cnt, 1);
        check("mismatch_last", bus.last_fail, 16'h1234);

        // No all_done at all.
        items.delete();
        add_item(16'h00AA, 32'h0000_00AA, 0, 1);
        do_run(-1);
        check("timeout_cnt_one", bus.timeout_cnt, 1);

        // all_done in the expiry cycle.
        items.delete();
        add_item(16'h5A5A, 32'h0000_5A5A, TO, 0);
        do_run(-1);
        check("expiry_tie_pass", bus.pass_cnt, 1);
        check("expiry_tie_no_timeout", bus.timeout_cnt, 0);

        // Zero-length run.
        items.delete();
        do_run(-1);

        // Reset during WAIT of word 2 of 4, then a fresh single-word run.
        items.delete();
        add_item(16'h1111, 32'h0000_1111, 2, 0);
        add_item(16'h2222, 32'h0000_2222, 10, 0);
        add_item(16'h3333, 32'h0000_3333, 2, 0);
        add_item(16'h4444, 32'h0000_4444, 2, 0);
        do_run(1);
        items.delete();
        add_item(16'h0F0F, 32'h0000_0F0F, 6, 1);
        do_run(-1);
        check("after_reset_pass", bus.pass_cnt, 1);

        for (int r = 0; r < 6; r++) begin
            items.delete();
            add_random($urandom_range(1, 6));
            do_run(-1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shiyan_sequencer.md
SHIYAN_SEQUENCER -- requirements
Module: shiyan_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 1023: maximum cycles to wait for all_done per word.
REQ-002 SHALL have parameter CNT_W, default 10: width of the word-count and result counters.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: one-cycle pulse that begins a run; ignored unless busy=0.
REQ-006 SHALL have port num_words, input, CNT_W: words per run; sampled on the accepted start.
REQ-007 SHALL have port word_req, output, 1: one-cycle request for the next test word.
REQ-008 SHALL have port word_in, input, 16: test word from the source.
REQ-009 SHALL have port word_valid, input, 1: word_in is valid this cycle.
REQ-010 SHALL have port input_binary, output, 16: word driven to the conversion chain.
REQ-011 SHALL have port en_shiyan, output, 1: one-cycle launch pulse to the conversion chain.
REQ-012 SHALL have port all_done, input, 1: conversion chain finished; out_b is valid.
REQ-013 SHALL have port out_b, input, 32: recovered binary from the conversion chain.
REQ-014 SHALL have port busy, output, 1: run in progress.
REQ-015 SHALL have port seq_done, output, 1: one-cycle pulse at the end of a run.
REQ-016 SHALL have ports pass_cnt, fail_cnt and timeout_cnt, outputs, CNT_W each: result counters.
REQ-017 SHALL have port last_fail, output, 16: most recent word that failed or timed out.

Function
REQ-018 SHALL implement FSM states IDLE, FETCH, ISSUE, WAIT, CHECK, FIN.
REQ-019 IDLE: on start with num_words!=0, SHALL clear pass_cnt, fail_cnt and timeout_cnt, load the remaining-word counter, and go to FETCH.
REQ-020 IDLE: on start with num_words=0, SHALL pulse seq_done the next cycle, leave counters unchanged, and stay in IDLE.
REQ-021 On entry to FETCH, SHALL pulse word_req once.
REQ-022 FETCH: SHALL wait indefinitely for word_valid, with no timeout.
REQ-023 FETCH: on word_valid, SHALL latch word_in into input_binary and go to ISSUE.
REQ-024 ISSUE: SHALL assert en_shiyan for exactly one cycle, clear the timeout timer, and go to WAIT.
REQ-025 WAIT: on all_done, SHALL register out_b and go to CHECK.
REQ-026 WAIT: if TIMEOUT_CYC cycles elapse with no all_done, SHALL increment timeout_cnt, set last_fail=input_binary, and go to CHECK with the compare result suppressed.
REQ-027 If all_done arrives in the same cycle the timer expires, all_done SHALL win and no timeout is counted.
REQ-028 CHECK (non-timeout): pass SHALL mean out_b[15:0]==input_binary and out_b[31:16]==0.
REQ-029 CHECK: on pass, SHALL increment pass_cnt.
REQ-030 CHECK: on fail, SHALL increment fail_cnt and set last_fail=input_binary.
REQ-031 CHECK: SHALL decrement the remaining-word counter, then go to FETCH if it is nonzero, else to FIN.
REQ-032 FIN: SHALL pulse seq_done for one cycle and return to IDLE.
REQ-033 busy SHALL be 1 in every state except IDLE.
REQ-034 Counters SHALL saturate at all-ones and never wrap.
REQ-035 all_done and word_valid outside WAIT and FETCH respectively SHALL be ignored.
REQ-036 start while busy=1 SHALL be ignored.
REQ-037 Latency from word_valid to en_shiyan SHALL be exactly 2 cycles.
REQ-038 Latency from all_done to the counter update SHALL be exactly 2 cycles.

Reset
REQ-039 rst=0 SHALL asynchronously force IDLE.
REQ-040 rst=0 SHALL clear every output, all counters, last_fail, input_binary and the timer to 0.
REQ-041 Reset mid-run SHALL abandon the run with no seq_done pulse.
REQ-042 After reset release, operation SHALL resume only on a fresh start.

Structure
REQ-043 Package shiyan_pkg SHALL hold the FSM state encoding, the default TIMEOUT_CYC and the 16/32 data-width constants.
REQ-044 The timeout counter SHALL be a sub-module shiyan_timer (ports clr, en, expired).
REQ-045 All other logic SHALL be in a single module.

Verification
REQ-046 Run num_words=3, words 0x0001/0x00FF/0xFFFF, chain returns zero-extended copies -> pass_cnt=3, fail_cnt=0, one seq_done.
REQ-047 Word 0x1234 with out_b=0x00001235 -> fail_cnt=1, last_fail=0x1234.
REQ-048 Word 0x00AA, all_done never asserted, TIMEOUT_CYC=16 -> timeout_cnt=1 after 16 WAIT cycles, then run ends normally.
REQ-049 all_done in the exact timer-expiry cycle -> pass_cnt increments, timeout_cnt=0.
REQ-050 rst=0 during WAIT of word 2 of 4 -> all outputs 0 immediately, no seq_done; a new start with num_words=1 completes with pass_cnt=1.
REQ-051 start with num_words=0 -> seq_done 1 cycle later, word_req and en_shiyan never asserted.
